// File: rtl/sd_dat_deser.sv
// sd_dat_deser: SD card DAT-line deserializer; shifts 1 or NumLanes bits per sample strobe, MSb first, into WordBits-wide words.
// Latency: word_valid_o rises one cycle after the sample that completes a word; done_o pulses one cycle after the last word (or CRC).
// Backpressure: single output register with valid/ready; a word completing while it is full and not accepted is dropped and sets overflow_o.
// Optional per-lane CRC-16 check is compiled in with `define SDHCI_DESER_CRC_EN.
module sd_dat_deser #(
    parameter int NumLanes = 4,
    parameter int WordBits = 32,
    parameter int MaxWords = 128
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           start_i,
    input  logic                           abort_i,
    input  logic                           wide_i,
    input  logic [$clog2(MaxWords+1)-1:0]  blk_words_i,
    input  logic                           sample_en_i,
    input  logic [NumLanes-1:0]            dat_i,
    output logic [WordBits-1:0]            word_o,
    output logic                           word_valid_o,
    input  logic                           word_ready_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           overflow_o
`ifdef SDHCI_DESER_CRC_EN
    ,
    output logic                           crc_err_o
`endif
);

    localparam int BlkW = $clog2(MaxWords + 1);
    localparam int BitW = $clog2(WordBits + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
`ifdef SDHCI_DESER_CRC_EN
        S_CRC   = 2'd2,
`endif
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                wide_q;
    logic [BlkW-1:0]     blk_q;
    logic [BlkW-1:0]     word_cnt_q;
    logic [BitW-1:0]     bit_cnt_q;
    logic [WordBits-1:0] sreg_q;
    logic [WordBits-1:0] sreg_d;
    logic [BitW-1:0]     spw;
    logic                start_ok;
    logic                sample_shift;
    logic                word_done;
    logic                last_word;

    // Samples per word depend on the lane mode captured at start.
    assign spw          = wide_q ? BitW'(WordBits / NumLanes) : BitW'(WordBits);
    assign start_ok     = (state_q == S_IDLE) && start_i && !abort_i;
    assign sample_shift = (state_q == S_SHIFT) && sample_en_i;
    assign word_done    = sample_shift && (bit_cnt_q == spw - 1'b1);
    assign last_word    = (word_cnt_q == blk_q - 1'b1);
    assign sreg_d       = wide_q ? {sreg_q[WordBits-NumLanes-1:0], dat_i}
                                 : {sreg_q[WordBits-2:0], dat_i[0]};

`ifdef SDHCI_DESER_CRC_EN
    logic [15:0] crc_q [NumLanes];
    logic        crc_err_q;
    logic        crc_done;

    assign crc_done  = (state_q == S_CRC) && sample_en_i && (bit_cnt_q == BitW'(15));
    assign crc_err_o = crc_err_q;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction
`endif

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; abort overrides everything else.
    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start_i) state_d = (blk_words_i == '0) ? S_DONE : S_SHIFT;
`ifdef SDHCI_DESER_CRC_EN
                S_SHIFT: if (word_done && last_word) state_d = S_CRC;
                S_CRC:   if (crc_done) state_d = S_DONE;
`else
                S_SHIFT: if (word_done && last_word) state_d = S_DONE;
`endif
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM-decoded status outputs.
    always_comb begin
        busy_o = (state_q != S_IDLE);
        done_o = (state_q == S_DONE);
    end

    // Shift register, bit/word counters and block configuration captured at start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wide_q     <= 1'b0;
            blk_q      <= '0;
            word_cnt_q <= '0;
            bit_cnt_q  <= '0;
            sreg_q     <= '0;
        end else if (abort_i) begin
            word_cnt_q <= '0;
            bit_cnt_q  <= '0;
            sreg_q     <= '0;
        end else if (start_ok) begin
            wide_q     <= wide_i;
            blk_q      <= blk_words_i;
            word_cnt_q <= '0;
            bit_cnt_q  <= '0;
            sreg_q     <= '0;
        end else if (sample_shift) begin
            sreg_q <= sreg_d;
            if (word_done) begin
                bit_cnt_q  <= '0;
                word_cnt_q <= word_cnt_q + 1'b1;
            end else begin
                bit_cnt_q  <= bit_cnt_q + 1'b1;
            end
`ifdef SDHCI_DESER_CRC_EN
        end else if ((state_q == S_CRC) && sample_en_i) begin
            bit_cnt_q <= crc_done ? '0 : bit_cnt_q + 1'b1;
`endif
        end
    end

    // Output register: load on completion if empty or being drained, otherwise drop and flag overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_o       <= '0;
            word_valid_o <= 1'b0;
            overflow_o   <= 1'b0;
        end else begin
            if (word_done && !abort_i && (!word_valid_o || word_ready_i)) begin
                word_o       <= sreg_d;
                word_valid_o <= 1'b1;
            end else if (word_valid_o && word_ready_i) begin
                word_valid_o <= 1'b0;
            end
            if (start_ok)
                overflow_o <= 1'b0;
            else if (word_done && !abort_i && word_valid_o && !word_ready_i)
                overflow_o <= 1'b1;
        end
    end

`ifdef SDHCI_DESER_CRC_EN
    // Per-lane CRC: accumulate over data samples, then compare against the 16 trailing bits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int l = 0; l < NumLanes; l++) crc_q[l] <= '0;
            crc_err_q <= 1'b0;
        end else if (abort_i) begin
            for (int l = 0; l < NumLanes; l++) crc_q[l] <= '0;
        end else if (start_ok) begin
            for (int l = 0; l < NumLanes; l++) crc_q[l] <= '0;
            crc_err_q <= 1'b0;
        end else if (sample_shift) begin
            for (int l = 0; l < NumLanes; l++)
                if (l == 0 || wide_q) crc_q[l] <= crc_step(crc_q[l], dat_i[l]);
        end else if ((state_q == S_CRC) && sample_en_i) begin
            for (int l = 0; l < NumLanes; l++) begin
                if (l == 0 || wide_q) begin
                    if (dat_i[l] != crc_q[l][15]) crc_err_q <= 1'b1;
                    crc_q[l] <= {crc_q[l][14:0], 1'b0};
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_sd_dat_deser.sv
// Self-checking bench for sd_dat_deser with default parameters (4 lanes, 32-bit words).
// Reference model works on whole words and a one-entry buffer occupancy flag; CRCs from a bitwise CRC-16 over each lane stream.
// Directed cases from the block's examples plus randomized blocks with random gaps and random consumer readiness.
module tb_sd_dat_deser;

    localparam int NL = 4;
    localparam int WB = 32;
    localparam int MW = 128;
    localparam int BW = $clog2(MW + 1);

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          start_i;
    logic          abort_i;
    logic          wide_i;
    logic [BW-1:0] blk_words_i;
    logic          sample_en_i;
    logic [NL-1:0] dat_i;
    logic [WB-1:0] word_o;
    logic          word_valid_o;
    logic          word_ready_i;
    logic          busy_o;
    logic          done_o;
    logic          overflow_o;
`ifdef SDHCI_DESER_CRC_EN
    logic          crc_err_o;
    logic [15:0]   crc_m [NL];
`endif

    sd_dat_deser #(.NumLanes(NL), .WordBits(WB), .MaxWords(MW)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .wide_i       (wide_i),
        .blk_words_i  (blk_words_i),
        .sample_en_i  (sample_en_i),
        .dat_i        (dat_i),
        .word_o       (word_o),
        .word_valid_o (word_valid_o),
        .word_ready_i (word_ready_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .overflow_o   (overflow_o)
`ifdef SDHCI_DESER_CRC_EN
        ,
        .crc_err_o    (crc_err_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int          errors = 0;
    int          checks = 0;
    int          done_cnt = 0;
    int          blk_d0 = 0;
    int          rdy_mode = 0;   // 0 = ready low, 1 = ready high, 2 = random
    bit          mfull = 1'b0;   // model: output buffer holds a word
    bit          m_ovf = 1'b0;   // model: overflow flag
    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];
    logic [31:0] wa, wb, wr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

`ifdef SDHCI_DESER_CRC_EN
    function automatic logic [15:0] crc16(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction
`endif

    // One clock: pick readiness, record handshakes, advance the word-level model, then compare valid.
    task automatic tick(input bit complete, input logic [31:0] w);
        case (rdy_mode)
            0:       word_ready_i = 1'b0;
            1:       word_ready_i = 1'b1;
            default: word_ready_i = 1'($urandom_range(0, 1));
        endcase
        if (word_valid_o && word_ready_i) got_q.push_back(word_o);
        if (complete) begin
            if (mfull && !word_ready_i) m_ovf = 1'b1;
            else begin
                mfull = 1'b1;
                exp_q.push_back(w);
            end
        end else if (mfull && word_ready_i) begin
            mfull = 1'b0;
        end
        @(posedge clk_i);
        #1;
        if (done_o) done_cnt++;
        check("valid", 32'(word_valid_o), 32'(mfull));
    endtask

    task automatic do_start(input bit wide, input int n);
        blk_d0      = done_cnt;
        wide_i      = wide;
        blk_words_i = BW'(n);
        start_i     = 1'b1;
        m_ovf       = 1'b0;
`ifdef SDHCI_DESER_CRC_EN
        for (int l = 0; l < NL; l++) crc_m[l] = 16'h0;
`endif
        tick(1'b0, 32'h0);
        start_i = 1'b0;
        wide_i  = 1'($urandom_range(0, 1));
        blk_words_i = BW'($urandom);
    endtask

    // Send nsamp samples of word w (full word when nsamp equals samples per word) with random idle gaps.
    task automatic send_word(input bit wide, input logic [31:0] w, input int maxgap, input int nsamp);
        int spw;
        spw = wide ? WB / NL : WB;
        for (int s = 0; s < nsamp; s++) begin
            repeat ($urandom_range(0, maxgap)) begin
                sample_en_i = 1'b0;
                dat_i = NL'($urandom);
                tick(1'b0, 32'h0);
            end
            sample_en_i = 1'b1;
            if (wide) dat_i = w[31-4*s -: 4];
            else begin
                dat_i = NL'($urandom);
                dat_i[0] = w[31-s];
            end
`ifdef SDHCI_DESER_CRC_EN
            for (int l = 0; l < NL; l++)
                if (wide || l == 0) crc_m[l] = crc16(crc_m[l], dat_i[l]);
`endif
            tick(s == spw - 1, w);
        end
        sample_en_i = 1'b0;
    endtask

    task automatic finish_block(input bit wide, input int flip_lane);
`ifdef SDHCI_DESER_CRC_EN
        bit exp_err;
        for (int s = 0; s < 16; s++) begin
            sample_en_i = 1'b1;
            dat_i = NL'($urandom);
            for (int l = 0; l < NL; l++)
                if (wide || l == 0) dat_i[l] = crc_m[l][15-s] ^ (l == flip_lane && s == 5);
            tick(1'b0, 32'h0);
        end
        sample_en_i = 1'b0;
        exp_err = (flip_lane == 0) || (wide && flip_lane > 0);
`endif
        tick(1'b0, 32'h0);
        check("busy_end", 32'(busy_o), 32'h0);
        check("done_once", 32'(done_cnt - blk_d0), 32'd1);
`ifdef SDHCI_DESER_CRC_EN
        check("crc_err", 32'(crc_err_o), 32'(exp_err));
`endif
    endtask

    task automatic drain();
        rdy_mode = 1;
        repeat (3) tick(1'b0, 32'h0);
        check("word_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check("word", got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0; wide_i = 1'b0;
        blk_words_i = '0; sample_en_i = 1'b0; dat_i = '0; word_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_word", word_o, 32'h0);
        check("rst_valid", 32'(word_valid_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_done", 32'(done_o), 32'h0);
        check("rst_ovf", 32'(overflow_o), 32'h0);
`ifdef SDHCI_DESER_CRC_EN
        check("rst_crc", 32'(crc_err_o), 32'h0);
`endif
        rst_ni = 1'b1;
        tick(1'b0, 32'h0);

        // Narrow mode, single word 0xDEADBEEF.
        rdy_mode = 0;
        do_start(1'b0, 1);
        check("busy_shift", 32'(busy_o), 32'h1);
        send_word(1'b0, 32'hDEADBEEF, 0, 32);
        check("deadbeef", word_o, 32'hDEADBEEF);
        finish_block(1'b0, -1);
        check("deadbeef_hold", word_o, 32'hDEADBEEF);
        drain();

        // Wide mode, nibbles 1..8.
        rdy_mode = 0;
        do_start(1'b1, 1);
        send_word(1'b1, 32'h12345678, 0, 8);
        check("wide_word", word_o, 32'h12345678);
        finish_block(1'b1, -1);
        drain();

        // Two words with ready held low: second dropped.
        rdy_mode = 0;
        wa = $urandom; wb = $urandom;
        do_start(1'b0, 2);
        send_word(1'b0, wa, 1, 32);
        send_word(1'b0, wb, 1, 32);
        finish_block(1'b0, -1);
        check("ovf_set", 32'(overflow_o), 32'(m_ovf));
        check("ovf_first_held", word_o, wa);

        // Abort mid-word with a pending word; the pending word is kept.
        do_start(1'b0, 1);
        check("ovf_clr_start", 32'(overflow_o), 32'h0);
        send_word(1'b0, $urandom, 0, 10);
        abort_i = 1'b1;
        tick(1'b0, 32'h0);
        abort_i = 1'b0;
        check("abort_idle", 32'(busy_o), 32'h0);
        check("abort_no_done", 32'(done_cnt - blk_d0), 32'h0);
        check("abort_keep", word_o, wa);
        abort_i = 1'b1; start_i = 1'b1; blk_words_i = BW'(1);
        tick(1'b0, 32'h0);
        abort_i = 1'b0; start_i = 1'b0;
        check("abort_over_start", 32'(busy_o), 32'h0);
        drain();
        rdy_mode = 0;
        do_start(1'b0, 1);
        send_word(1'b0, 32'hA5A5A5A5, 0, 32);
        check("after_abort", word_o, 32'hA5A5A5A5);
        finish_block(1'b0, -1);
        drain();

        // Empty block goes straight to DONE.
        do_start(1'b0, 0);
        check("blk0_done", 32'(done_o), 32'h1);
        tick(1'b0, 32'h0);
        check("blk0_idle", 32'(busy_o), 32'h0);
        check("blk0_once", 32'(done_cnt - blk_d0), 32'h1);

        // Same words with and without gaps between strobes.
        wr = $urandom;
        for (int g = 0; g < 4; g += 3) begin
            rdy_mode = 1;
            do_start(1'b0, 1);
            send_word(1'b0, wr, g, 32);
            finish_block(1'b0, -1);
            check("gap_word", word_o, wr);
            do_start(1'b1, 1);
            send_word(1'b1, ~wr, g, 8);
            finish_block(1'b1, -1);
            check("gap_word_wide", word_o, ~wr);
        end
        drain();

        // Randomized blocks with random consumer readiness.
        for (int b = 0; b < 8; b++) begin
            bit wd;
            int n;
            wd = 1'($urandom_range(0, 1));
            n  = $urandom_range(1, 4);
            rdy_mode = 2;
            do_start(wd, n);
            for (int k = 0; k < n; k++) send_word(wd, $urandom, 2, wd ? 8 : 32);
            finish_block(wd, -1);
            check("rand_ovf", 32'(overflow_o), 32'(m_ovf));
            drain();
        end

`ifdef SDHCI_DESER_CRC_EN
        // 512 bytes of 0xFF on 4 lanes: good CRCs, then one flipped CRC bit on lane 2.
        for (int f = 0; f < 2; f++) begin
            rdy_mode = 1;
            do_start(1'b1, 128);
            for (int k = 0; k < 128; k++) send_word(1'b1, 32'hFFFFFFFF, 0, 8);
            finish_block(1'b1, f == 0 ? -1 : 2);
            drain();
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
